// File: rtl/pipe_pkg.sv
// Shared widths and payload layouts for the pipeline stage boundaries.
// Instantiations take DATA_W from the *_W constants so payload and register width stay in step.
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_WB_W = 2;

    localparam int IFID_W  = 2 * XLEN;
    localparam int IDEX_W  = 4 * XLEN + REG_IDX_W;
    localparam int EXMEM_W = 2 * XLEN + REG_IDX_W;
    localparam int MEMWB_W = 2 * XLEN + REG_IDX_W;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      instr;
    } ifid_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
    } idex_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] rd;
    } exmem_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]      read_data;
        logic [XLEN-1:0]      alu_addr;
        logic [REG_IDX_W-1:0] rd;
    } memwb_payload_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// flush, and control masking so an empty slot never presents non-zero control.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = CTRL_WB_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_m_valid;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_valid;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DATA_W-1:0] r_s_data;

    logic              w_m_valid_next;
    logic [CTRL_W-1:0] w_m_ctrl_next;
    logic [DATA_W-1:0] w_m_data_next;
    logic              w_s_valid_next;
    logic [CTRL_W-1:0] w_s_ctrl_next;
    logic [DATA_W-1:0] w_s_data_next;

    logic              w_accept;
    logic              w_drain;

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_m_valid & out_ready;

    assign out_valid = r_m_valid;
    assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;
    assign out_data  = r_m_data;
    assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

    generate
        if (SKID_EN) begin : g_skid
            // in_ready depends only on a register, so downstream ready never reaches upstream.
            assign in_ready = ~r_s_valid;

            always_comb begin
                w_m_valid_next = r_m_valid;
                w_m_ctrl_next  = r_m_ctrl;
                w_m_data_next  = r_m_data;
                w_s_valid_next = r_s_valid;
                w_s_ctrl_next  = r_s_ctrl;
                w_s_data_next  = r_s_data;

                if (w_drain) begin
                    if (r_s_valid) begin
                        w_m_valid_next = 1'b1;
                        w_m_ctrl_next  = r_s_ctrl;
                        w_m_data_next  = r_s_data;
                        if (w_accept) begin
                            w_s_ctrl_next = in_ctrl;
                            w_s_data_next = in_data;
                        end else begin
                            w_s_valid_next = 1'b0;
                            w_s_ctrl_next  = '0;
                        end
                    end else if (w_accept) begin
                        w_m_ctrl_next = in_ctrl;
                        w_m_data_next = in_data;
                    end else begin
                        w_m_valid_next = 1'b0;
                        w_m_ctrl_next  = '0;
                    end
                end else if (w_accept) begin
                    if (r_m_valid) begin
                        // Downstream stalled: park the new beat behind the held one.
                        w_s_valid_next = 1'b1;
                        w_s_ctrl_next  = in_ctrl;
                        w_s_data_next  = in_data;
                    end else begin
                        w_m_valid_next = 1'b1;
                        w_m_ctrl_next  = in_ctrl;
                        w_m_data_next  = in_data;
                    end
                end
            end
        end else begin : g_single
            assign in_ready = ~r_m_valid | out_ready;

            always_comb begin
                w_m_valid_next = r_m_valid;
                w_m_ctrl_next  = r_m_ctrl;
                w_m_data_next  = r_m_data;
                w_s_valid_next = 1'b0;
                w_s_ctrl_next  = '0;
                w_s_data_next  = '0;

                if (w_accept) begin
                    w_m_valid_next = 1'b1;
                    w_m_ctrl_next  = in_ctrl;
                    w_m_data_next  = in_data;
                end else if (w_drain) begin
                    w_m_valid_next = 1'b0;
                    w_m_ctrl_next  = '0;
                end
            end
        end
    endgenerate

    // Flush squashes validity and control but leaves payload in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
        end else begin
            r_m_valid <= w_m_valid_next;
            r_m_ctrl  <= w_m_ctrl_next;
            r_m_data  <= w_m_data_next;
            r_s_valid <= w_s_valid_next;
            r_s_ctrl  <= w_s_ctrl_next;
            r_s_data  <= w_s_data_next;
        end
    end

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) r_s_valid |-> r_m_valid);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: one skid build and one single-register build.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int DW = IFID_W;

    typedef struct packed {
        logic [1:0]    c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, in_valid, out_ready, in_ready, out_valid;
    logic [1:0]    in_ctrl, out_ctrl, occupancy;
    logic [DW-1:0] in_data, out_data;

    logic          flush0, in0_valid, out0_ready, in0_ready, out0_valid;
    logic [1:0]    in0_ctrl, out0_ctrl, occ0;
    logic [DW-1:0] in0_data, out0_data;

    beat_t q[$];
    beat_t q0[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CTRL_WB_W), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CTRL_WB_W), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in0_valid), .in_ready(in0_ready), .in_ctrl(in0_ctrl), .in_data(in0_data),
        .out_valid(out0_valid), .out_ready(out0_ready), .out_ctrl(out0_ctrl), .out_data(out0_data),
        .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a beat and hold it until the handshake completes (bounded).
    task automatic push_beat(input logic [DW-1:0] d, input logic [1:0] c);
        logic ok;
        int   n;
        in_valid = 1'b1; in_data = d; in_ctrl = c;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        check("accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic push_beat0(input logic [DW-1:0] d, input logic [1:0] c);
        logic ok;
        int   n;
        in0_valid = 1'b1; in0_data = d; in0_ctrl = c;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = in0_ready;
            @(posedge clk); #1;
            n++;
        end
        check("accept0", {63'd0, ok}, 64'd1);
    endtask

    // Scoreboard for the skid build: held beats are exactly those accepted and not yet drained.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            q.delete();
        end else begin
            check("occupancy", occupancy, q.size());
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < 2);
            if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
            if (out_valid && out_ready && q.size() != 0) begin
                b = q.pop_front();
                check("out_data", out_data, b.d);
                check("out_ctrl", out_ctrl, b.c);
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            q0.delete();
        end else begin
            check("occ0", occ0, q0.size());
            check("out0_valid", out0_valid, q0.size() != 0);
            check("in0_ready", in0_ready, (q0.size() == 0) || out0_ready);
            if (!out0_valid) check("bubble_ctrl0", out0_ctrl, 0);
            if (out0_valid && out0_ready && q0.size() != 0) begin
                b = q0.pop_front();
                check("out0_data", out0_data, b.d);
                check("out0_ctrl", out0_ctrl, b.c);
            end
            if (flush0) q0.delete();
            else if (in0_valid && in0_ready) q0.push_back({in0_ctrl, in0_data});
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = 2'b00; in_data = '0;
        flush0 = 1'b0; in0_valid = 1'b0; out0_ready = 1'b1;
        in0_ctrl = 2'b00; in0_data = '0;
        tick(2);
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        tick(1);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) push_beat(DW'(i), 2'b11);
        in_valid = 1'b0;
        tick(3);

        // Backpressure fills both entries, third beat waits upstream
        out_ready = 1'b0;
        push_beat(DW'(32'hA), 2'b11);
        push_beat(DW'(32'hB), 2'b11);
        in_valid = 1'b1; in_data = DW'(32'hC); in_ctrl = 2'b11;
        repeat (2) begin
            @(negedge clk);
            check("bp_occupancy", occupancy, 2);
            check("bp_in_ready", in_ready, 0);
        end
        tick(1);
        out_ready = 1'b1;
        push_beat(DW'(32'hC), 2'b11);
        in_valid = 1'b0;
        tick(4);

        // Bubble masking with live-looking control on the input
        in_ctrl = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("gap_out_valid", out_valid, 0);
            check("gap_out_ctrl", out_ctrl, 0);
        end
        tick(1);

        // Flush with both entries full and a concurrent beat
        out_ready = 1'b0;
        push_beat(DW'(32'h10), 2'b01);
        push_beat(DW'(32'h11), 2'b10);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_flush_occ", occupancy, 2);
        tick(1);
        flush = 1'b1; in_valid = 1'b1; in_data = DW'(32'hD); in_ctrl = 2'b11;
        tick(1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_occupancy", occupancy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_in_ready", in_ready, 1);
        tick(1);
        out_ready = 1'b1;
        tick(3);

        // Beat draining in the flush cycle is delivered
        push_beat(DW'(32'hE), 2'b10);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_drain_valid", out_valid, 1);
        check("flush_drain_data", out_data, DW'(32'hE));
        tick(1);
        flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_flush_valid", out_valid, 0);
        end
        tick(1);

        // Reset while stalled with two entries
        out_ready = 1'b0;
        push_beat(DW'(32'h30), 2'b11);
        push_beat(DW'(32'h31), 2'b11);
        in_valid = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_stall_valid", out_valid, 0);
            check("rst_stall_occ", occupancy, 0);
        end
        tick(1);

        // Single-register build: ready follows downstream combinationally
        out0_ready = 1'b0;
        push_beat0(DW'(32'h21), 2'b01);
        in0_valid = 1'b1; in0_data = DW'(32'h22); in0_ctrl = 2'b10;
        repeat (2) begin
            @(negedge clk);
            check("s0_in_ready", in0_ready, 0);
            check("s0_occ", occ0, 1);
        end
        tick(1);
        out0_ready = 1'b1;
        push_beat0(DW'(32'h22), 2'b10);
        in0_valid = 1'b0;
        @(negedge clk);
        check("s0_second_data", out0_data, DW'(32'h22));
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
